// File: rtl/guest_ctrl_pkg.sv
// Shared types for the guest reset / clock-enable controller.
// The FSM state enum and the bit positions of rst_cause_o.
package guest_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    STRETCH = 2'd2,
    ALIGN   = 2'd3
  } guest_state_e;

  localparam int CAUSE_W   = 4;
  localparam int CAUSE_BTN = 0;
  localparam int CAUSE_OSD = 1;
  localparam int CAUSE_CFG = 2;
  localparam int CAUSE_DL  = 3;

endpackage

// File: rtl/ce_divider.sv
// Free-running power-of-two divider producing NUM_CE registered
// single-cycle clock enables. ce_o[k] pulses once every 2^(CE_BASE+k)
// cycles, and all enables coincide when the divider wraps to zero.
module ce_divider #(
  parameter int NUM_CE  = 2,
  parameter int CE_BASE = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  output logic [NUM_CE-1:0] ce_o
);

  localparam int DW = CE_BASE + NUM_CE - 1;

  logic [DW-1:0] div;

  // Count up every cycle and flag when the low bits for each enable are all zero.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div  <= '0;
      ce_o <= '0;
    end else begin
      div <= div + DW'(1);
      for (int k = 0; k < NUM_CE; k++) begin
        ce_o[k] <= ((div & DW'((1 << (CE_BASE + k)) - 1)) == '0);
      end
    end
  end

endmodule

// File: rtl/guest_reset_ce_ctrl.sv
// Guest clock-enable generator and reset sequencer.
// Reset sources (button, OSD reset bit, masked config change, ROM
// download) are merged, held while any is active, stretched for MIN_RST
// cycles and released on the cycle after a slowest-enable pulse.
// Optional feature macro: GUEST_RST_SYNC_EN adds a two-flop synchroniser
// on btn_reset_n_i (button-to-reset latency becomes 3 cycles).
// Handshake note: there is no valid/ready traffic here; every input is a
// level sampled on each clk_sys edge and every output is a registered level
// or single-cycle pulse.
module guest_reset_ce_ctrl
  import guest_ctrl_pkg::*;
#(
  parameter int                  NUM_CE   = 2,
  parameter int                  CE_BASE  = 2,
  parameter int                  STATUS_W = 32,
  parameter logic [STATUS_W-1:0] CFG_MASK = 32'h0000_001F,
  parameter int                  RST_BIT  = 17,
  parameter logic [7:0]          DL_INDEX = 8'd1,
  parameter int                  MIN_RST  = 16
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                btn_reset_n_i,
  input  logic [STATUS_W-1:0] status_i,
  input  logic                ioctl_download_i,
  input  logic [7:0]          ioctl_index_i,
  output logic [NUM_CE-1:0]   ce_o,
  output logic                guest_reset_o,
  output logic                por_o,
  output logic                cfg_changed_o,
  output logic [CAUSE_W-1:0]  rst_cause_o,
  output guest_state_e        dbg_state_o
);

  localparam int                CNT_W    = (MIN_RST > 1) ? $clog2(MIN_RST) : 1;
  localparam logic [CNT_W-1:0]  RST_LOAD = CNT_W'(MIN_RST - 1);

  guest_state_e         state;
  logic [CNT_W-1:0]     counter;
  logic [STATUS_W-1:0]  cfg_q;
  logic [STATUS_W-1:0]  cfg_masked;
  logic                 chg;
  logic                 btn_n;
  logic                 dl;
  logic [CAUSE_W-1:0]   src;
  logic                 any_src;

  ce_divider #(
    .NUM_CE  (NUM_CE),
    .CE_BASE (CE_BASE)
  ) u_ce_divider (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce_o    (ce_o)
  );

`ifdef GUEST_RST_SYNC_EN
  logic [1:0] btn_sync;

  // Bring the asynchronous button into clk_sys; idles released (high).
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      btn_sync <= 2'b11;
    end else begin
      btn_sync <= {btn_sync[0], btn_reset_n_i};
    end
  end

  assign btn_n = btn_sync[1];
`else
  assign btn_n = btn_reset_n_i;
`endif

  assign cfg_masked = status_i & CFG_MASK;
  assign chg        = (cfg_masked != cfg_q);
  assign dl         = ioctl_download_i & (ioctl_index_i == DL_INDEX);

  // Collect the reset sources into cause-bit order.
  always_comb begin
    src            = '0;
    src[CAUSE_BTN] = ~btn_n;
    src[CAUSE_OSD] = status_i[RST_BIT];
    src[CAUSE_CFG] = chg;
    src[CAUSE_DL]  = dl;
  end

  assign any_src = |src;

  // Track the masked config; the reset load means a config present at reset is not a change.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cfg_q         <= cfg_masked;
      cfg_changed_o <= 1'b0;
    end else begin
      cfg_q         <= cfg_masked;
      cfg_changed_o <= chg;
    end
  end

  // Reset sequencer: hold while sources are active, stretch, then release aligned to the slowest enable.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state         <= STRETCH;
      counter       <= RST_LOAD;
      guest_reset_o <= 1'b1;
      por_o         <= 1'b1;
      rst_cause_o   <= '0;
    end else begin
      case (state)
        RUN: begin
          guest_reset_o <= 1'b0;
          if (any_src) begin
            rst_cause_o   <= src;
            guest_reset_o <= 1'b1;
            counter       <= RST_LOAD;
            state         <= HOLD;
          end
        end
        HOLD: begin
          guest_reset_o <= 1'b1;
          rst_cause_o   <= rst_cause_o | src;
          if (any_src) begin
            counter <= RST_LOAD;
          end else begin
            state <= STRETCH;
          end
        end
        STRETCH: begin
          if (any_src) begin
            rst_cause_o <= rst_cause_o | src;
            counter     <= RST_LOAD;
            state       <= HOLD;
          end else if (counter == '0) begin
            state <= ALIGN;
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        ALIGN: begin
          if (any_src) begin
            rst_cause_o <= rst_cause_o | src;
            counter     <= RST_LOAD;
            state       <= HOLD;
          end else if (ce_o[NUM_CE-1]) begin
            guest_reset_o <= 1'b0;
            por_o         <= 1'b0;
            state         <= RUN;
          end
        end
        default: begin
          state <= STRETCH;
        end
      endcase
    end
  end

  assign dbg_state_o = state;

endmodule

// File: tb/tb_guest_reset_ce_ctrl.sv
// Self-checking bench for guest_reset_ce_ctrl (default parameters).
// Reference model works on an edge index n since reset release: enables
// are n mod 2^(CE_BASE+k) == 0, and a reset sequence ends at the first edge
// that is MIN_RST+2 edges past the last active source and follows a
// slowest-enable pulse.
module tb_guest_reset_ce_ctrl;
  import guest_ctrl_pkg::*;

  localparam int                 NUM_CE   = 2;
  localparam int                 CE_BASE  = 2;
  localparam int                 STATUS_W = 32;
  localparam logic [31:0]        CFG_MASK = 32'h0000_001F;
  localparam int                 RST_BIT  = 17;
  localparam logic [7:0]         DL_INDEX = 8'd1;
  localparam int                 MIN_RST  = 16;
  localparam int                 P_SLOW   = 1 << (CE_BASE + NUM_CE - 1);

  // clock / reset
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic                rst;
  logic                btn_reset_n;
  logic [STATUS_W-1:0] status;
  logic                ioctl_download;
  logic [7:0]          ioctl_index;
  logic [NUM_CE-1:0]   ce;
  logic                guest_reset;
  logic                por;
  logic                cfg_changed;
  logic [3:0]          rst_cause;
  guest_state_e        dbg_state;

  guest_reset_ce_ctrl #(
    .NUM_CE   (NUM_CE),
    .CE_BASE  (CE_BASE),
    .STATUS_W (STATUS_W),
    .CFG_MASK (CFG_MASK),
    .RST_BIT  (RST_BIT),
    .DL_INDEX (DL_INDEX),
    .MIN_RST  (MIN_RST)
  ) dut (
    .clk_sys          (clk_sys),
    .reset            (rst),
    .btn_reset_n_i    (btn_reset_n),
    .status_i         (status),
    .ioctl_download_i (ioctl_download),
    .ioctl_index_i    (ioctl_index),
    .ce_o             (ce),
    .guest_reset_o    (guest_reset),
    .por_o            (por),
    .cfg_changed_o    (cfg_changed),
    .rst_cause_o      (rst_cause),
    .dbg_state_o      (dbg_state)
  );

  // scoreboard state
  int          compared   = 0;
  int          mismatched = 0;
  logic [3:0]  exp_q[$];

  // reference model state
  int                  n;
  bit                  m_active;
  bit                  m_por;
  logic [3:0]          m_cause;
  int                  m_last_src;
  logic [STATUS_W-1:0] m_cfg_q;
  bit                  m_s1, m_s2;
  logic [NUM_CE-1:0]   e_ce;
  bit                  e_cfg;

  // release monitor
  bit prev_gr = 1'b1;
  int rel_count = 0;
  int last_rel_edge = -100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clk_sys edge using the inputs the DUT sampled.
  task automatic model_edge();
    logic                btn_used;
    logic [STATUS_W-1:0] masked;
    bit                  chg_m, dl_m, align_ok;
    logic [3:0]          src_m;
    if (rst) begin
      n          = -1;
      m_active   = 1'b1;
      m_por      = 1'b1;
      m_cause    = 4'b0;
      m_last_src = -2;
      m_cfg_q    = status & CFG_MASK;
      m_s1       = 1'b1;
      m_s2       = 1'b1;
      e_ce       = '0;
      e_cfg      = 1'b0;
    end else begin
      n++;
`ifdef GUEST_RST_SYNC_EN
      btn_used = m_s2;
      m_s2     = m_s1;
      m_s1     = btn_reset_n;
`else
      btn_used = btn_reset_n;
`endif
      masked  = status & CFG_MASK;
      chg_m   = (masked != m_cfg_q);
      m_cfg_q = masked;
      dl_m    = ioctl_download && (ioctl_index == DL_INDEX);
      src_m   = {dl_m, chg_m, status[RST_BIT], ~btn_used};
      align_ok = (n >= 1) && (((n - 1) % P_SLOW) == 0);
      if (!m_active) begin
        if (src_m != 4'b0) begin
          m_active   = 1'b1;
          m_cause    = src_m;
          m_last_src = n;
        end
      end else if (src_m != 4'b0) begin
        m_cause    = m_cause | src_m;
        m_last_src = n;
      end else if ((n >= m_last_src + MIN_RST + 2) && align_ok) begin
        m_active = 1'b0;
        m_por    = 1'b0;
        exp_q.push_back(m_cause);
      end
      for (int k = 0; k < NUM_CE; k++) begin
        e_ce[k] = ((n % (1 << (CE_BASE + k))) == 0);
      end
      e_cfg = chg_m;
    end
  endtask

  // One clock: update model at the edge, compare outputs 1 time unit later.
  task automatic step();
    logic [3:0] exp_cause;
    @(posedge clk_sys);
    model_edge();
    #1;
    check("ce", 32'(ce), 32'(e_ce));
    check("guest_reset", 32'(guest_reset), 32'(m_active));
    check("por", 32'(por), 32'(m_por));
    check("cfg_changed", 32'(cfg_changed), 32'(e_cfg));
    check("rst_cause", 32'(rst_cause), 32'(m_cause));
    if (prev_gr && !guest_reset && !rst) begin
      rel_count++;
      last_rel_edge = n;
      if (exp_q.size() > 0) begin
        exp_cause = exp_q.pop_front();
        check("release_cause", 32'(rst_cause), 32'(exp_cause));
      end else begin
        check("release_expected", 32'(1), 32'(0));
      end
    end
    prev_gr = guest_reset;
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  int n0;
  int r0;

  initial begin
    rst            = 1'b1;
    btn_reset_n    = 1'b1;
    status         = '0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    #1;

    // reset values
    cycles(3);
    check("rst_ce", 32'(ce), 32'(0));
    check("rst_guest_reset", 32'(guest_reset), 32'(1));
    check("rst_por", 32'(por), 32'(1));
    check("rst_cause0", 32'(rst_cause), 32'(0));

    // power-on release: first enables at n=0, release one cycle after ce[1] at n=16
    rst = 1'b0;
    cycles(1);
    check("first_ce", 32'(ce), 32'(2'b11));
    cycles(16);
    check("por_hold", 32'(guest_reset), 32'(1));
    cycles(1);
    check("por_release", 32'(guest_reset), 32'(0));
    check("por_low", 32'(por), 32'(0));
    check("por_release_edge", 32'(last_rel_edge), 32'(17));
    cycles(10);

    // config change in RUN
    status = 32'h0000_0002;
    r0 = rel_count;
    cycles(1);
    n0 = n;
    check("cfg_pulse", 32'(cfg_changed), 32'(1));
    check("cfg_reset_rise", 32'(guest_reset), 32'(1));
    cycles(1);
    check("cfg_pulse_once", 32'(cfg_changed), 32'(0));
    cycles(30);
    check("cfg_released", 32'(rel_count - r0), 32'(1));
    check("cfg_len", 32'((last_rel_edge - n0 >= MIN_RST + 2) && (last_rel_edge - n0 <= MIN_RST + 1 + P_SLOW)), 32'(1));
    check("cfg_cause", 32'(rst_cause), 32'(4'b0100));

    // download to the guest index holds reset
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    cycles(100);
    check("dl_hold", 32'(guest_reset), 32'(1));
    ioctl_download = 1'b0;
    cycles(MIN_RST + 1);
    check("dl_stretch", 32'(guest_reset), 32'(1));
    cycles(20);
    check("dl_released", 32'(guest_reset), 32'(0));
    check("dl_cause", 32'(rst_cause), 32'(4'b1000));

    // download to another index does nothing
    r0 = rel_count;
    ioctl_index    = 8'd2;
    ioctl_download = 1'b1;
    cycles(100);
    ioctl_download = 1'b0;
    check("dl_other_idx", 32'(guest_reset), 32'(0));
    check("dl_other_no_release", 32'(rel_count), 32'(r0));

    // button and OSD reset together
    btn_reset_n     = 1'b0;
    status[RST_BIT] = 1'b1;
    cycles(1);
    btn_reset_n     = 1'b1;
    status[RST_BIT] = 1'b0;
    cycles(45);
    check("btn_osd_cause", 32'(rst_cause), 32'(4'b0011));
    check("btn_osd_released", 32'(guest_reset), 32'(0));

    // OSD re-pulse while stretching with counter at 5
    status[RST_BIT] = 1'b1;
    cycles(1);
    status[RST_BIT] = 1'b0;
    cycles(11);
    status[RST_BIT] = 1'b1;
    cycles(1);
    n0 = n;
    status[RST_BIT] = 1'b0;
    cycles(40);
    check("repulse_len", 32'((last_rel_edge - n0 >= MIN_RST + 2) && (last_rel_edge - n0 <= MIN_RST + 1 + P_SLOW)), 32'(1));
    check("repulse_cause", 32'(rst_cause), 32'(4'b0010));

    // block reset while waiting for alignment
    status[RST_BIT] = 1'b1;
    cycles(1);
    status[RST_BIT] = 1'b0;
    cycles(17);
    rst = 1'b1;
    cycles(2);
    check("midrst_ce", 32'(ce), 32'(0));
    check("midrst_guest_reset", 32'(guest_reset), 32'(1));
    check("midrst_por", 32'(por), 32'(1));
    check("midrst_cause", 32'(rst_cause), 32'(0));
    rst = 1'b0;
    cycles(30);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [STATUS_W-1:0] keep;
      keep = status & CFG_MASK;
      if ($urandom_range(49) == 0) keep = $urandom & CFG_MASK;
      status = ($urandom & ~CFG_MASK & ~(32'h1 << RST_BIT)) | keep;
      status[RST_BIT] = ($urandom_range(79) == 0);
      btn_reset_n = ($urandom_range(59) != 0);
      if ($urandom_range(99) == 0) ioctl_download = ~ioctl_download;
      if ($urandom_range(29) == 0) ioctl_index = 8'($urandom_range(3));
      rst = ($urandom_range(299) == 0);
      cycles(1);
    end
    rst            = 1'b0;
    ioctl_download = 1'b0;
    btn_reset_n    = 1'b1;
    status[RST_BIT] = 1'b0;
    cycles(40);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
